// File: rtl/serial_pkg.sv
// serial_pkg: FSM state encoding and frame-length constants shared by serial receiver/transmitter
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN adds the PARITY state and one parity bit per frame.
package serial_pkg;
   typedef enum logic [1:0] {
      IDLE,
      DATA,
`ifdef SERIAL_FRAME_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   localparam int START_BITS = 1;
   localparam int STOP_BITS = 1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif
   function automatic int frame_len(input int data_w);
      return START_BITS + data_w + PARITY_BITS + STOP_BITS;
   endfunction
endpackage

// File: rtl/serial_frame_rx_hold.sv
// serial_frame_rx_hold: output holding register with valid/ready handshake and sticky overrun
// Ports: clk, rst (async, active-high); load/load_data = good frame word; data_ready = consumer accept;
//        data_out/data_valid = held word; overrun = good frame arrived while the word was unconsumed.
module serial_frame_rx_hold #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              data_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              overrun
);
   logic take;
   assign take = data_valid && data_ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         data_out <= '0;
         data_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (load && (!data_valid || take)) begin
            data_out <= load_data;
            data_valid <= 1'b1;
         end else if (take) data_valid <= 1'b0;
         if (load && data_valid && !data_ready) overrun <= 1'b1;
      end
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: one-bit-per-clock serial frame receiver (start, DATA_W bits LSB-first, [parity], stop)
// Ports: clk, rst (async, active-high); serial_in = line; data_out/data_valid/data_ready = output handshake;
//        frame_err = one-cycle pulse on bad stop/parity; overrun = sticky dropped-word flag.
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN enables an even-parity bit after the data bits.
module serial_frame_rx
   import serial_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              frame_err,
   output logic              overrun
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   state_t state, state_nx;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic good, bad, frame_ok;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic pbit;
   // even parity: data bits XOR parity bit must be zero
   assign frame_ok = (serial_in == IDLE_LVL) && !(^shreg ^ pbit);
`else
   assign frame_ok = serial_in == IDLE_LVL;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt <= '0;
         frame_err <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         pbit <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         frame_err <= bad;
         if (state == IDLE) cnt <= '0;
         else if (state == DATA) cnt <= cnt + 1'b1;
         if (state == DATA) shreg <= {serial_in, shreg[DATA_W-1:1]};
`ifdef SERIAL_FRAME_RX_PARITY_EN
         if (state == PARITY) pbit <= serial_in;
`endif
      end
   always_comb begin
      state_nx = state;
      good = 1'b0;
      bad = 1'b0;
      case (state)
         IDLE: state_nx = (serial_in != IDLE_LVL) ? DATA : IDLE;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         DATA: state_nx = (cnt == CNT_W'(DATA_W - 1)) ? PARITY : DATA;
         PARITY: state_nx = STOP;
`else
         DATA: state_nx = (cnt == CNT_W'(DATA_W - 1)) ? STOP : DATA;
`endif
         STOP: begin
            state_nx = IDLE;
            good = frame_ok;
            bad = !frame_ok;
         end
         default: state_nx = IDLE;
      endcase
   end
   serial_frame_rx_hold #(.DATA_W(DATA_W)) u_hold (
      .clk(clk),
      .rst(rst),
      .load(good),
      .load_data(shreg),
      .data_ready(data_ready),
      .data_out(data_out),
      .data_valid(data_valid),
      .overrun(overrun)
   );
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed self-checking bench for serial_frame_rx (DATA_W=8, IDLE_LVL=0)
module tb_serial_frame_rx;
`ifdef SERIAL_FRAME_RX_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif
   logic clk, rst, serial_in, data_ready, data_valid, frame_err, overrun;
   logic [7:0] data_out;
   int pass = 0, total = 0;
   serial_frame_rx #(.DATA_W(8), .IDLE_LVL(1'b0)) dut (
      .clk(clk),
      .rst(rst),
      .serial_in(serial_in),
      .data_out(data_out),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .frame_err(frame_err),
      .overrun(overrun)
   );
   always #5 clk = ~clk;
   function automatic logic [FL-1:0] mk(input logic [7:0] d, input logic stop_b);
`ifdef SERIAL_FRAME_RX_PARITY_EN
      return {stop_b, ^d, d, 1'b1};
`else
      return {stop_b, d, 1'b1};
`endif
   endfunction
   task automatic edge1(input logic b);
      serial_in = b;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [FL-1:0] fr);
      for (int i = 0; i < FL; i++) edge1(fr[i]);
      serial_in = 1'b0;
   endtask
   task automatic do_reset;
      rst = 1'b1;
      serial_in = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask
   task automatic test_reset;
      edge1(1'b1);
      edge1(1'b1);
      edge1(1'b0);
      rst = 1'b1;
      total++; if (frame_err !== 1'b0) $display("FAIL rst_async_err got %b exp 0", frame_err); else pass++;
      #20;
      total++; if (frame_err !== 1'b0) $display("FAIL rst_hold_err got %b exp 0", frame_err); else pass++;
      serial_in = 1'b0;
      rst = 1'b0;
      total++; if (data_out !== 8'h00) $display("FAIL rst_data got %h exp 00", data_out); else pass++;
      total++; if (data_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", data_valid); else pass++;
      total++; if (overrun !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun); else pass++;
      total++; if (dut.state !== serial_pkg::IDLE) $display("FAIL rst_state got %0d exp IDLE", dut.state); else pass++;
      edge1(1'b0);
      total++; if (frame_err !== 1'b0) $display("FAIL rst_post_err got %b exp 0", frame_err); else pass++;
      total++; if (dut.state !== serial_pkg::IDLE) $display("FAIL rst_post_state got %0d exp IDLE", dut.state); else pass++;
   endtask
   task automatic test_good;
      logic [FL-1:0] fr;
      fr = mk(8'hA5, 1'b0);
      data_ready = 1'b1;
      for (int i = 0; i < FL; i++) begin
         edge1(fr[i]);
         total++; if (data_valid !== (i == FL - 1)) $display("FAIL good_latency edge %0d got %b exp %b", i + 1, data_valid, i == FL - 1); else pass++;
      end
      total++; if (data_out !== 8'hA5) $display("FAIL good_data got %h exp a5", data_out); else pass++;
      edge1(1'b0);
      total++; if (data_valid !== 1'b0) $display("FAIL good_one_cycle got %b exp 0", data_valid); else pass++;
      total++; if (frame_err !== 1'b0) $display("FAIL good_err got %b exp 0", frame_err); else pass++;
   endtask
   task automatic test_bad_stop;
      data_ready = 1'b1;
      send(mk(8'h5A, 1'b1));
      total++; if (frame_err !== 1'b1) $display("FAIL bad_err got %b exp 1", frame_err); else pass++;
      total++; if (data_valid !== 1'b0) $display("FAIL bad_valid got %b exp 0", data_valid); else pass++;
      total++; if (data_out !== 8'hA5) $display("FAIL bad_data_kept got %h exp a5", data_out); else pass++;
      edge1(1'b0);
      total++; if (frame_err !== 1'b0) $display("FAIL bad_err_pulse got %b exp 0", frame_err); else pass++;
      send(mk(8'h01, 1'b0));
      total++; if (data_valid !== 1'b1) $display("FAIL bad_next_valid got %b exp 1", data_valid); else pass++;
      total++; if (data_out !== 8'h01) $display("FAIL bad_next_data got %h exp 01", data_out); else pass++;
      edge1(1'b0);
   endtask
   task automatic test_simultaneous;
      logic [FL-1:0] fr;
      data_ready = 1'b0;
      send(mk(8'h3C, 1'b0));
      total++; if (data_out !== 8'h3C) $display("FAIL sim_first got %h exp 3c", data_out); else pass++;
      fr = mk(8'hC3, 1'b0);
      for (int i = 0; i < FL; i++) begin
         if (i == FL - 1) data_ready = 1'b1;
         edge1(fr[i]);
         if (i == FL - 2) begin
            total++; if (data_out !== 8'h3C || data_valid !== 1'b1) $display("FAIL sim_stable got %h/%b exp 3c/1", data_out, data_valid); else pass++;
         end
      end
      serial_in = 1'b0;
      total++; if (data_valid !== 1'b1) $display("FAIL sim_valid got %b exp 1", data_valid); else pass++;
      total++; if (data_out !== 8'hC3) $display("FAIL sim_data got %h exp c3", data_out); else pass++;
      total++; if (overrun !== 1'b0) $display("FAIL sim_overrun got %b exp 0", overrun); else pass++;
      edge1(1'b0);
      total++; if (data_valid !== 1'b0) $display("FAIL sim_consume got %b exp 0", data_valid); else pass++;
   endtask
   task automatic test_back_to_back;
      data_ready = 1'b0;
      send(mk(8'hA5, 1'b0));
      total++; if (data_valid !== 1'b1 || data_out !== 8'hA5) $display("FAIL b2b_first got %h/%b exp a5/1", data_out, data_valid); else pass++;
      total++; if (overrun !== 1'b0) $display("FAIL b2b_first_ovr got %b exp 0", overrun); else pass++;
      send(mk(8'h3C, 1'b0));
      total++; if (data_out !== 8'hA5) $display("FAIL b2b_hold got %h exp a5", data_out); else pass++;
      total++; if (overrun !== 1'b1) $display("FAIL b2b_overrun got %b exp 1", overrun); else pass++;
      total++; if (data_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", data_valid); else pass++;
      data_ready = 1'b1;
      edge1(1'b0);
      total++; if (data_valid !== 1'b0) $display("FAIL b2b_consume got %b exp 0", data_valid); else pass++;
      total++; if (overrun !== 1'b1) $display("FAIL b2b_sticky got %b exp 1", overrun); else pass++;
      data_ready = 1'b0;
   endtask
`ifdef SERIAL_FRAME_RX_PARITY_EN
   task automatic test_parity;
      logic [FL-1:0] fr;
      data_ready = 1'b1;
      fr = mk(8'h07, 1'b0);
      send(fr);
      total++; if (data_valid !== 1'b1 || data_out !== 8'h07) $display("FAIL par_good got %h/%b exp 07/1", data_out, data_valid); else pass++;
      total++; if (frame_err !== 1'b0) $display("FAIL par_good_err got %b exp 0", frame_err); else pass++;
      edge1(1'b0);
      fr[9] = 1'b0;
      send(fr);
      total++; if (frame_err !== 1'b1) $display("FAIL par_bad_err got %b exp 1", frame_err); else pass++;
      total++; if (data_valid !== 1'b0) $display("FAIL par_bad_valid got %b exp 0", data_valid); else pass++;
      edge1(1'b0);
      total++; if (frame_err !== 1'b0) $display("FAIL par_bad_pulse got %b exp 0", frame_err); else pass++;
   endtask
`endif
   initial begin
      clk = 1'b0;
      rst = 1'b1;
      serial_in = 1'b0;
      data_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset;
      test_good;
      test_bad_stop;
      test_simultaneous;
      test_back_to_back;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      do_reset;
      test_parity;
`endif
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
